// File: rtl/sap_step_run_ctrl.sv
// rtl/sap_step_run_ctrl.sv - SAP clock front end: key/switch sync, debounce, auto-run pacing, halt latch.
// Optional KEY_REPEAT_EN macro adds held-key auto-repeat in manual mode.
module sap_step_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_DIV        = 50000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_DIV      = 5000000
) (
    input  logic clock_fpga,
    input  logic reset,
    input  logic key0,
    input  logic selecao_manual_auto,
    input  logic prog_run,
    input  logic hlt_sig,
    output logic sap_tick,
    output logic halted,
    output logic mode_auto,
    output logic running
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PS_W = $clog2(AUTO_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(AUTO_DIV - 1);

    localparam logic [1:0] ST_REL = 2'd0;
    localparam logic [1:0] ST_PW  = 2'd1;
    localparam logic [1:0] ST_PRS = 2'd2;
    localparam logic [1:0] ST_RW  = 2'd3;

    logic            r_key_meta, r_key_s;
    logic            r_mode_meta, r_mode_s;
    logic            r_run_meta, r_run_s;
    logic            r_mode_auto;
    logic            r_halted;
    logic            r_running;
    logic            r_tick;
    logic [1:0]      r_st;
    logic [DB_W-1:0] r_db_cnt;
    logic [PS_W-1:0] r_ps_cnt;

    logic [1:0]      w_st_nxt;
    logic [DB_W-1:0] w_db_nxt;
    logic [DB_W-1:0] w_db_inc;
    logic            w_press;
    logic            w_tick_en;
    logic            w_mode_chg;
    logic            w_ps_wrap;
    logic            w_halted_nxt;
    logic            w_rp_pulse;

    assign sap_tick  = r_tick;
    assign halted    = r_halted;
    assign mode_auto = r_mode_auto;
    assign running   = r_running;

    // The key idles high, so its synchronizer resets to the released level.
    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            r_key_meta  <= 1'b1;
            r_key_s     <= 1'b1;
            r_mode_meta <= 1'b0;
            r_mode_s    <= 1'b0;
            r_run_meta  <= 1'b0;
            r_run_s     <= 1'b0;
            r_mode_auto <= 1'b0;
        end else begin
            r_key_meta  <= key0;
            r_key_s     <= r_key_meta;
            r_mode_meta <= selecao_manual_auto;
            r_mode_s    <= r_mode_meta;
            r_run_meta  <= prog_run;
            r_run_s     <= r_run_meta;
            r_mode_auto <= r_mode_s;
        end
    end

    assign w_db_inc = r_db_cnt + 1'b1;

    always_comb begin
        w_st_nxt = r_st;
        w_db_nxt = r_db_cnt;
        w_press  = 1'b0;
        case (r_st)
            ST_REL: begin
                if (!r_key_s) begin
                    w_st_nxt = ST_PW;
                    w_db_nxt = '0;
                end
            end
            ST_PW: begin
                if (r_key_s) begin
                    w_st_nxt = ST_REL;
                    w_db_nxt = '0;
                end else if (w_db_inc == DB_LAST) begin
                    w_st_nxt = ST_PRS;
                    w_db_nxt = '0;
                    w_press  = 1'b1;
                end else begin
                    w_db_nxt = w_db_inc;
                end
            end
            ST_PRS: begin
                if (r_key_s) begin
                    w_st_nxt = ST_RW;
                    w_db_nxt = '0;
                end
            end
            ST_RW: begin
                if (!r_key_s) begin
                    w_st_nxt = ST_PRS;
                    w_db_nxt = '0;
                end else if (w_db_inc == DB_LAST) begin
                    w_st_nxt = ST_REL;
                    w_db_nxt = '0;
                end else begin
                    w_db_nxt = w_db_inc;
                end
            end
            default: begin
                w_st_nxt = ST_REL;
                w_db_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            r_st     <= ST_REL;
            r_db_cnt <= '0;
        end else begin
            r_st     <= w_st_nxt;
            r_db_cnt <= w_db_nxt;
        end
    end

    assign w_tick_en    = r_run_s & ~r_halted & ~hlt_sig;
    assign w_mode_chg   = r_mode_s ^ r_mode_auto;
    assign w_ps_wrap    = (r_ps_cnt == PS_LAST);
    assign w_halted_nxt = r_run_s & (r_halted | hlt_sig);

`ifdef KEY_REPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_DIV) ? REPEAT_DELAY : REPEAT_DIV;
    localparam int RP_W   = $clog2(RP_MAX);
    localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_DIV_LAST   = RP_W'(REPEAT_DIV - 1);

    logic [RP_W-1:0] r_rp_cnt;
    logic            r_rp_phase;
    logic            w_rp_active;
    logic [RP_W-1:0] w_rp_last;

    // Phase 0 waits out the initial hold delay, phase 1 paces the repeats.
    assign w_rp_active = (r_st == ST_PRS) & ~r_mode_s & w_tick_en & ~w_mode_chg;
    assign w_rp_last   = r_rp_phase ? RP_DIV_LAST : RP_DELAY_LAST;
    assign w_rp_pulse  = w_rp_active & (r_rp_cnt == w_rp_last);

    always_ff @(posedge clock_fpga) begin
        if (reset || !w_rp_active) begin
            r_rp_cnt   <= '0;
            r_rp_phase <= 1'b0;
        end else if (w_rp_pulse) begin
            r_rp_cnt   <= '0;
            r_rp_phase <= 1'b1;
        end else begin
            r_rp_cnt   <= r_rp_cnt + 1'b1;
        end
    end
`else
    logic w_unused_rep;
    assign w_unused_rep = ^{32'(REPEAT_DELAY), 32'(REPEAT_DIV)};
    assign w_rp_pulse   = 1'b0;
`endif

    always_ff @(posedge clock_fpga) begin
        if (reset || !w_tick_en || w_mode_chg || !r_mode_s || w_ps_wrap) begin
            r_ps_cnt <= '0;
        end else begin
            r_ps_cnt <= r_ps_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            r_halted  <= 1'b0;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_halted  <= w_halted_nxt;
            r_running <= r_run_s & ~w_halted_nxt;
            r_tick    <= w_tick_en & ~w_mode_chg &
                         (r_mode_s ? w_ps_wrap : (w_press | w_rp_pulse));
        end
    end

endmodule

// File: doc/sap_step_run_ctrl.md
Name: sap_step_run_ctrl

Overview:
Front-end clock-control stage for the SAP computer, running entirely in the clock_fpga domain. It synchronizes and debounces the step key and mode switches, generates paced auto-run ticks, and latches halt. It emits a single-cycle clock-enable `sap_tick` consumed by the downstream SAP clock circuit and datapath in place of raw key edges.

Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized samples required to accept a key level change (10 ms at 50 MHz); minimum 2.
- `AUTO_DIV`, 50000000: clock_fpga cycles per auto-mode tick (1 Hz at 50 MHz); minimum 2.
- `REPEAT_DELAY`, 25000000: cycles a key must be held before auto-repeat starts (used only with KEY_REPEAT_EN).
- `REPEAT_DIV`, 5000000: cycles between repeat ticks (used only with KEY_REPEAT_EN).

Ports:
- `clock_fpga`, in, 1: sole clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `key0`, in, 1: step button; asynchronous, active-low.
- `selecao_manual_auto`, in, 1: asynchronous switch; 1 = auto, 0 = manual.
- `prog_run`, in, 1: asynchronous switch; 1 = run, 0 = program/load (no ticks).
- `hlt_sig`, in, 1: HLT decode from the control unit; synchronous to clock_fpga.
- `sap_tick`, out, 1: one-cycle clock-enable pulse for the SAP.
- `halted`, out, 1: halt latched.
- `mode_auto`, out, 1: synchronized, registered mode.
- `running`, out, 1: `prog_run_s & ~halted`, registered.

Behaviour:
- Interface: one clock, `clock_fpga`; reset is synchronous and active-high on port `reset`.
- Reset values:
  - All outputs are 0.
  - Synchronizers: `key0` stages = 1; switch stages = 0.
  - Debounce FSM = REL; prescaler = 0; debounce counter = 0.
- Synchronization: 2-FF synchronizers on `key0`, `selecao_manual_auto` and `prog_run`, giving `key_s`, `mode_s` and `run_s`. Each lags its input by 2 edges. `mode_auto` is `mode_s`, registered one further cycle.
- Debounce FSM states:
  - REL → PW when `key_s`=0; counter cleared.
  - PW: counter increments each edge `key_s`=0. Returns to REL if `key_s`=1 (counter cleared). Goes to PRS on the edge the counter reaches DEBOUNCE_CYCLES-1; `press` is asserted that same edge.
  - PRS → RW when `key_s`=1; counter cleared.
  - RW: counter increments each edge `key_s`=1. Returns to PRS if `key_s`=0. Goes to REL on reaching DEBOUNCE_CYCLES-1.
- Key held through reset: the FSM leaves reset in REL, so a held key is debounced and yields exactly one press.
- Press latency: `press` fires on the edge that samples the DEBOUNCE_CYCLES-th consecutive `key_s`=0.
- Tick enable: `tick_en = run_s & ~halted & ~hlt_sig`.
- Manual mode (`mode_s`=0):
  - `sap_tick` is registered and equals `press & tick_en`, so it is high in the cycle after the accepting edge.
  - Exactly one tick per accepted press; key bounce produces no extra ticks.
- Auto mode (`mode_s`=1):
  - The prescaler counts 0..AUTO_DIV-1 while `tick_en` is high, then wraps to 0.
  - On the wrap edge, `sap_tick` is registered high for one cycle.
  - The prescaler holds at 0 while `tick_en` is low.
  - The first tick comes AUTO_DIV cycles after `tick_en` rises.
  - `press` is ignored in auto mode.
- Mode change (`mode_s` differs from registered `mode_auto`):
  - Prescaler is cleared.
  - Any press on that edge is discarded.
  - No tick in the following cycle.
- Halt:
  - `halted` is set on any edge where `hlt_sig`=1 and `run_s`=1.
  - `halted` clears only on `reset` or on any edge where `run_s`=0.
  - `hlt_sig`=1 suppresses a tick on the same edge, including a coincident prescaler wrap or press.
- Program mode (`run_s`=0): no ticks, prescaler 0, `halted` 0, `running` 0. The FSM keeps tracking the key, but presses are dropped.
- Reset asserted mid-debounce or mid-prescale: everything returns to reset values on that edge; no tick in the next cycle.
- Width rules: counters are sized with `$clog2` of their maximum; comparisons are against parameter-1; no overflow beyond wrap.

Optional Feature:
- Macro: `KEY_REPEAT_EN`.
- When defined, in manual mode with `tick_en`, holding the key in PRS generates:
  - the normal press tick;
  - then a further tick after REPEAT_DELAY cycles in PRS;
  - then one tick every REPEAT_DIV cycles until the FSM leaves PRS.
- The repeat counter clears on leaving PRS, on a mode change, or on `halted`.
- When undefined, there is no repeat logic and exactly one tick per press; `REPEAT_DELAY` and `REPEAT_DIV` are unused.

Test Plan:
1. DEBOUNCE_CYCLES=4, manual mode, `prog_run`=1: drop `key0` low and hold 20 cycles → exactly one `sap_tick`, 7 cycles after the first low sample (2 sync + 4 debounce + 1 register). Release → no tick.
2. Manual mode: toggle `key0` low/high every 2 cycles for 20 cycles, then hold low → zero ticks during bounce, one tick after the hold.
3. AUTO_DIV=5, auto mode, `prog_run`=1 → ticks at cycles 5, 10, 15 after `tick_en` rises. Each tick is 1 cycle wide; no ticks with `prog_run`=0.
4. Auto mode: assert `hlt_sig` for 1 cycle coincident with a prescaler wrap → no tick; `halted`=1 and `running`=0 persist. Drop `prog_run` to 0 then back to 1 → `halted`=0 and ticks resume 5 cycles later.
5. Assert `reset` for 1 cycle mid-debounce (counter=2) with the key held → all outputs 0. The FSM re-debounces from REL and one tick follows 4 debounce cycles later.
6. KEY_REPEAT_EN, REPEAT_DELAY=10, REPEAT_DIV=3, key held 30 cycles after acceptance → ticks at +1, +11, +14, +17, … until release.
